ex_operand_stage: RTL and testbench
===================================

# ex_operand_stage

ID/EX pipeline stage that sits directly upstream of the execute ALU in the RISC-V core. It captures one decoded instruction and resolves its source operands, using forwarding from the MEM and WB stages. It stalls on load-use hazards and presents registered `operand_a`, `operand_b` and one-hot ALU selects to the ALU under a valid/ready handshake. It holds one instruction and supports a synchronous flush for branch redirects.

## Interface
- `WIDTH`, 32, datapath width (power of two)
- `REG_AW`, 5, register address width
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `flush` in 1: synchronous discard of the held and incoming instruction.
- `in_valid` in 1: decode presents an instruction.
- `in_ready` out 1: stage accepts this cycle.
- `in_pc`, `in_imm` in WIDTH: PC and sign-extended immediate.
- `in_rs1_addr`, `in_rs2_addr` in REG_AW: source register numbers.
- `in_rs1_data`, `in_rs2_data` in WIDTH: register-file read data.
- `in_use_pc` in 1: operand_a = PC (AUIPC/JAL).
- `in_use_imm` in 1: operand_b = immediate.
- `in_alu_op` in 4: operation code: 0 add, 1 sub, 2 mul, 3 mulh, 4 mulhsu, 5 mulhu, 6 and, 7 or, 8 xor, 9 sll, 10 srl, 11 sra, 12 slt, 13 sltu. Codes 14 and 15 are no-op.
- `in_rd_addr` in REG_AW, `in_rd_we` in 1: destination register and write enable.
- `mem_rd_addr` in REG_AW, `mem_rd_we` in 1, `mem_is_load` in 1, `mem_data` in WIDTH: EX/MEM forwarding source.
- `wb_rd_addr` in REG_AW, `wb_rd_we` in 1, `wb_data` in WIDTH: MEM/WB forwarding source.
- `out_valid` out 1: operands and selects are valid.
- `out_ready` in 1: ALU/EX accepts.
- `operand_a`, `operand_b` out WIDTH: ALU operands.
- `alu_sel_add` … `alu_sel_sltu` out 1 each: 14 one-hot selects in the opcode order above.
- `out_pc` out WIDTH, `out_rd_addr` out REG_AW, `out_rd_we` out 1: sideband carried with the instruction.

## Operation
- The stage has three states.
  - IDLE: empty.
  - HOLD: instruction held, operands resolved.
  - LDWAIT: instruction held, at least one operand pending load data.
- `in_ready` = IDLE | (HOLD & `out_ready`). It is 0 in LDWAIT.
- A capture occurs on `in_valid & in_ready & ~flush`.
- Operand resolution at capture is done per source rsN:
  - If the address is 0, the value is 0.
  - Otherwise, a MEM match (`mem_rd_we`, addr≠0, equal) wins. If that MEM match has `mem_is_load`, the operand is marked pending. Otherwise the value is `mem_data`.
  - Otherwise, a WB match gives `wb_data`.
  - Otherwise, the value is `in_rsN_data`.
- Next state after capture: HOLD if no operand is pending, else LDWAIT.
- Snoop: in HOLD and LDWAIT, a WB write (we, addr≠0) that matches a held rsN address overwrites that rsN value and clears its pending bit. LDWAIT goes to HOLD when no pending bits remain.
- Output mux (on registered flags):
  - `operand_a` = use_pc ? pc : rs1 value.
  - `operand_b` = use_imm ? imm : rs2 value.
  - For sll/srl/sra, bits [WIDTH-1:log2(WIDTH)] of `operand_b` are forced to 0.
- Selects: registered one-hot decode of the opcode. All selects are 0 when `out_valid`=0 or the opcode is 14/15.
- `out_valid` = (state==HOLD).
- HOLD with `out_ready`=1 and no capture goes to IDLE. HOLD with `out_ready`=1 and a capture stays in HOLD or goes to LDWAIT; this is back-to-back.
- `flush` overrides everything: the next state is IDLE and any simultaneous capture is dropped.

## Timing
- Reset values:
  - State is IDLE.
  - All data and sideband registers are 0.
  - `out_valid`=0, all selects 0, `operand_a`/`operand_b`=0.
  - `in_ready`=1.
  - No capture occurs while `rst` is high.
- Latency: capture at edge N gives `out_valid` after edge N, i.e. one cycle, with no hazard.
- Load-use adds one cycle per cycle of waiting for the WB write. The typical case is exactly +1.
- Handshake:
  - Once `out_valid`=1, all outputs are held stable until the cycle with `out_ready`=1. WB snoop may update only a non-pending rs value whose register is being written, and only when it is not selected away by use_pc/use_imm.
  - A transfer occurs on `out_valid & out_ready`.
  - Sustained throughput is one instruction per cycle.
- A `flush` asserted in the same cycle as `out_valid & out_ready` means the transfer still completes on the EX side. The stage ends in IDLE.
- An asynchronous `rst` during LDWAIT or HOLD immediately drops `out_valid` and all selects.

## Test plan
- Reset then idle: `rst`=1 with `in_valid`=1 → no capture. After release, `in_ready`=1, `out_valid`=0 and all selects are 0.
- Basic add: rs1=5 (data 0x10), rs2=6 (data 0x22), op 0 → next cycle `out_valid`=1, A=0x10, B=0x22, only `alu_sel_add`=1.
- Forward priority: rs1=7, with MEM writing x7=0xAAAA (non-load) and WB writing x7=0xBBBB → A=0xAAAA. With rs1=0 and the same forwards → A=0.
- Load-use: rs2=9 with MEM load to x9 → LDWAIT, `out_valid`=0, `in_ready`=0. Next cycle WB writes x9=0x1234 → `out_valid` the following cycle with B=0x1234.
- Backpressure and shift mask: op 9 with use_imm, imm=0xFFFF_FFE3, `out_ready`=0 for 3 cycles → outputs stable with B=0x3. Release → one transfer, with `in_valid` back-to-back accepted in that same cycle.
- Flush: flush in HOLD with a simultaneous capture → IDLE next cycle, `out_valid`=0, and the captured instruction never appears.

Source files
------------

// File: rtl/ex_operand_stage.sv
// ID/EX operand stage: holds one decoded instruction, resolves rs1/rs2 via MEM/WB forwarding,
// stalls on load-use until the WB write arrives, and presents operands/selects under valid/ready.
module ex_operand_stage #(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_pc,
  input  logic [WIDTH-1:0]  in_imm,
  input  logic [REG_AW-1:0] in_rs1_addr,
  input  logic [REG_AW-1:0] in_rs2_addr,
  input  logic [WIDTH-1:0]  in_rs1_data,
  input  logic [WIDTH-1:0]  in_rs2_data,
  input  logic              in_use_pc,
  input  logic              in_use_imm,
  input  logic [3:0]        in_alu_op,
  input  logic [REG_AW-1:0] in_rd_addr,
  input  logic              in_rd_we,
  input  logic [REG_AW-1:0] mem_rd_addr,
  input  logic              mem_rd_we,
  input  logic              mem_is_load,
  input  logic [WIDTH-1:0]  mem_data,
  input  logic [REG_AW-1:0] wb_rd_addr,
  input  logic              wb_rd_we,
  input  logic [WIDTH-1:0]  wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  operand_a,
  output logic [WIDTH-1:0]  operand_b,
  output logic              alu_sel_add,
  output logic              alu_sel_sub,
  output logic              alu_sel_mul,
  output logic              alu_sel_mulh,
  output logic              alu_sel_mulhsu,
  output logic              alu_sel_mulhu,
  output logic              alu_sel_and,
  output logic              alu_sel_or,
  output logic              alu_sel_xor,
  output logic              alu_sel_sll,
  output logic              alu_sel_srl,
  output logic              alu_sel_sra,
  output logic              alu_sel_slt,
  output logic              alu_sel_sltu,
  output logic [WIDTH-1:0]  out_pc,
  output logic [REG_AW-1:0] out_rd_addr,
  output logic              out_rd_we
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] SH_MASK = {{(WIDTH-SHW){1'b0}}, {SHW{1'b1}}};

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_LDWAIT} state_t;

  state_t            r_state;
  logic [WIDTH-1:0]  r_pc, r_imm, r_rs1_val, r_rs2_val;
  logic [REG_AW-1:0] r_rs1_addr, r_rs2_addr, r_rd_addr;
  logic              r_rs1_pend, r_rs2_pend, r_use_pc, r_use_imm, r_rd_we, r_shift;
  logic [13:0]       r_sel;

  logic [WIDTH:0]    w_rs1_res, w_rs2_res;
  logic              w_capture, w_wb_hit1, w_wb_hit2, w_pend1_left, w_pend2_left, w_out_valid;
  logic [13:0]       w_sel_dec, w_sel_out;
  logic [WIDTH-1:0]  w_b_raw;

  // Result is {pending, value}; a load hit in MEM leaves the value to be filled by WB snoop.
  function automatic logic [WIDTH:0] resolve(
    input logic [REG_AW-1:0] addr,   input logic [WIDTH-1:0]  rf_data,
    input logic              m_we,   input logic [REG_AW-1:0] m_addr,
    input logic              m_load, input logic [WIDTH-1:0]  m_data,
    input logic              w_we,   input logic [REG_AW-1:0] w_addr,
    input logic [WIDTH-1:0]  w_data);
    if (addr == '0)                        resolve = '0;
    else if (m_we && m_addr == addr)       resolve = m_load ? {1'b1, {WIDTH{1'b0}}} : {1'b0, m_data};
    else if (w_we && w_addr == addr)       resolve = {1'b0, w_data};
    else                                   resolve = {1'b0, rf_data};
  endfunction

  assign w_rs1_res = resolve(in_rs1_addr, in_rs1_data, mem_rd_we, mem_rd_addr, mem_is_load,
                             mem_data, wb_rd_we, wb_rd_addr, wb_data);
  assign w_rs2_res = resolve(in_rs2_addr, in_rs2_data, mem_rd_we, mem_rd_addr, mem_is_load,
                             mem_data, wb_rd_we, wb_rd_addr, wb_data);

  assign in_ready     = (r_state == S_IDLE) || (r_state == S_HOLD && out_ready);
  assign w_capture    = in_valid && in_ready && !flush;
  assign w_wb_hit1    = wb_rd_we && (wb_rd_addr != '0) && (wb_rd_addr == r_rs1_addr);
  assign w_wb_hit2    = wb_rd_we && (wb_rd_addr != '0) && (wb_rd_addr == r_rs2_addr);
  assign w_pend1_left = r_rs1_pend && !w_wb_hit1;
  assign w_pend2_left = r_rs2_pend && !w_wb_hit2;
  assign w_sel_dec    = (in_alu_op < 4'd14) ? (14'd1 << in_alu_op) : 14'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pc       <= '0;
      r_imm      <= '0;
      r_rs1_val  <= '0;
      r_rs2_val  <= '0;
      r_rs1_addr <= '0;
      r_rs2_addr <= '0;
      r_rd_addr  <= '0;
      r_rs1_pend <= 1'b0;
      r_rs2_pend <= 1'b0;
      r_use_pc   <= 1'b0;
      r_use_imm  <= 1'b0;
      r_rd_we    <= 1'b0;
      r_shift    <= 1'b0;
      r_sel      <= '0;
    end else begin
      if (w_capture) begin
        r_pc       <= in_pc;
        r_imm      <= in_imm;
        r_rs1_addr <= in_rs1_addr;
        r_rs2_addr <= in_rs2_addr;
        r_rs1_val  <= w_rs1_res[WIDTH-1:0];
        r_rs2_val  <= w_rs2_res[WIDTH-1:0];
        r_rs1_pend <= w_rs1_res[WIDTH];
        r_rs2_pend <= w_rs2_res[WIDTH];
        r_use_pc   <= in_use_pc;
        r_use_imm  <= in_use_imm;
        r_rd_addr  <= in_rd_addr;
        r_rd_we    <= in_rd_we;
        r_shift    <= (in_alu_op >= 4'd9) && (in_alu_op <= 4'd11);
        r_sel      <= w_sel_dec;
      end else if (r_state != S_IDLE) begin
        if (w_wb_hit1) begin
          r_rs1_val  <= wb_data;
          r_rs1_pend <= 1'b0;
        end
        if (w_wb_hit2) begin
          r_rs2_val  <= wb_data;
          r_rs2_pend <= 1'b0;
        end
      end

      if (flush)
        r_state <= S_IDLE;
      else if (w_capture)
        r_state <= (w_rs1_res[WIDTH] || w_rs2_res[WIDTH]) ? S_LDWAIT : S_HOLD;
      else begin
        case (r_state)
          S_HOLD:   if (out_ready) r_state <= S_IDLE;
          S_LDWAIT: if (!w_pend1_left && !w_pend2_left) r_state <= S_HOLD;
          default:  r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign w_out_valid = (r_state == S_HOLD);
  assign out_valid   = w_out_valid;
  assign w_sel_out   = w_out_valid ? r_sel : 14'd0;
  assign operand_a   = r_use_pc ? r_pc : r_rs1_val;
  assign w_b_raw     = r_use_imm ? r_imm : r_rs2_val;
  // Shift amount lives in the low log2(WIDTH) bits only.
  assign operand_b   = r_shift ? (w_b_raw & SH_MASK) : w_b_raw;
  assign out_pc      = r_pc;
  assign out_rd_addr = r_rd_addr;
  assign out_rd_we   = r_rd_we;

  assign {alu_sel_sltu, alu_sel_slt, alu_sel_sra, alu_sel_srl, alu_sel_sll, alu_sel_xor,
          alu_sel_or, alu_sel_and, alu_sel_mulhu, alu_sel_mulhsu, alu_sel_mulh, alu_sel_mul,
          alu_sel_sub, alu_sel_add} = w_sel_out;
endmodule

// File: tb/tb_ex_operand_stage.sv
// Randomized + directed bench for ex_operand_stage against an occupancy/pending reference model.
module tb_ex_operand_stage;
  logic        clk = 1'b0, rst, flush, in_valid, in_ready, in_use_pc, in_use_imm, in_rd_we;
  logic [31:0] in_pc, in_imm, in_rs1_data, in_rs2_data, mem_data, wb_data;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr, mem_rd_addr, wb_rd_addr, out_rd_addr;
  logic [3:0]  in_alu_op;
  logic        mem_rd_we, mem_is_load, wb_rd_we, out_valid, out_ready, out_rd_we;
  logic [31:0] operand_a, operand_b, out_pc;
  logic        s_add, s_sub, s_mul, s_mulh, s_mulhsu, s_mulhu, s_and, s_or, s_xor;
  logic        s_sll, s_srl, s_sra, s_slt, s_sltu;
  logic [13:0] sel_v;

  int checks = 0;
  int errors = 0;

  // Reference model: one slot, two source values each with a "waiting for load" flag.
  logic        m_full, m_p1, m_p2, m_upc, m_uimm, m_we;
  logic [4:0]  m_a1, m_a2, m_rd;
  logic [31:0] m_v1, m_v2, m_pc, m_imm;
  logic [3:0]  m_op;

  ex_operand_stage #(.WIDTH(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_imm(in_imm), .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_use_pc(in_use_pc),
    .in_use_imm(in_use_imm), .in_alu_op(in_alu_op), .in_rd_addr(in_rd_addr), .in_rd_we(in_rd_we),
    .mem_rd_addr(mem_rd_addr), .mem_rd_we(mem_rd_we), .mem_is_load(mem_is_load),
    .mem_data(mem_data), .wb_rd_addr(wb_rd_addr), .wb_rd_we(wb_rd_we), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .operand_a(operand_a), .operand_b(operand_b),
    .alu_sel_add(s_add), .alu_sel_sub(s_sub), .alu_sel_mul(s_mul), .alu_sel_mulh(s_mulh),
    .alu_sel_mulhsu(s_mulhsu), .alu_sel_mulhu(s_mulhu), .alu_sel_and(s_and), .alu_sel_or(s_or),
    .alu_sel_xor(s_xor), .alu_sel_sll(s_sll), .alu_sel_srl(s_srl), .alu_sel_sra(s_sra),
    .alu_sel_slt(s_slt), .alu_sel_sltu(s_sltu), .out_pc(out_pc), .out_rd_addr(out_rd_addr),
    .out_rd_we(out_rd_we)
  );

  assign sel_v = {s_sltu, s_slt, s_sra, s_srl, s_sll, s_xor, s_or, s_and,
                  s_mulhu, s_mulhsu, s_mulh, s_mul, s_sub, s_add};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_full = 0; m_p1 = 0; m_p2 = 0; m_upc = 0; m_uimm = 0; m_we = 0;
    m_a1 = 0; m_a2 = 0; m_rd = 0; m_v1 = 0; m_v2 = 0; m_pc = 0; m_imm = 0; m_op = 0;
  endtask

  // {pending, value} for one source register at capture time.
  function automatic logic [32:0] fwd(input logic [4:0] a, input logic [31:0] rf);
    if (a == 0) return 33'd0;
    if (mem_rd_we && mem_rd_addr == a) return mem_is_load ? {1'b1, 32'd0} : {1'b0, mem_data};
    if (wb_rd_we && wb_rd_addr == a) return {1'b0, wb_data};
    return {1'b0, rf};
  endfunction

  function automatic logic exp_ready();
    return !m_full || (!m_p1 && !m_p2 && out_ready);
  endfunction

  task automatic model_edge();
    logic [32:0] r1, r2;
    logic cap;
    cap = in_valid && exp_ready() && !flush;
    if (flush) m_full = 0;
    else if (cap) begin
      r1 = fwd(in_rs1_addr, in_rs1_data);
      r2 = fwd(in_rs2_addr, in_rs2_data);
      m_full = 1; m_p1 = r1[32]; m_v1 = r1[31:0]; m_p2 = r2[32]; m_v2 = r2[31:0];
      m_a1 = in_rs1_addr; m_a2 = in_rs2_addr; m_pc = in_pc; m_imm = in_imm;
      m_upc = in_use_pc; m_uimm = in_use_imm; m_op = in_alu_op; m_rd = in_rd_addr;
      m_we = in_rd_we;
    end else if (m_full) begin
      if (!m_p1 && !m_p2 && out_ready) m_full = 0;
      else if (wb_rd_we && wb_rd_addr != 0) begin
        if (wb_rd_addr == m_a1) begin m_v1 = wb_data; m_p1 = 0; end
        if (wb_rd_addr == m_a2) begin m_v2 = wb_data; m_p2 = 0; end
      end
    end
  endtask

  task automatic check_outputs();
    logic        v;
    logic [31:0] eb;
    v  = m_full && !m_p1 && !m_p2;
    eb = m_uimm ? m_imm : m_v2;
    if (m_op == 9 || m_op == 10 || m_op == 11) eb = eb % 32;
    chk("out_valid", out_valid, v);
    chk("sel", sel_v, (v && m_op < 14) ? (64'd1 << m_op) : 64'd0);
    if (v) begin
      chk("operand_a", operand_a, m_upc ? m_pc : m_v1);
      chk("operand_b", operand_b, eb);
      chk("out_pc", out_pc, m_pc);
      chk("out_rd", {out_rd_we, out_rd_addr}, {m_we, m_rd});
    end
  endtask

  task automatic step();
    #1;
    chk("in_ready", in_ready, exp_ready());
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic idle_in();
    flush = 0; in_valid = 0; in_pc = 0; in_imm = 0; in_rs1_addr = 0; in_rs2_addr = 0;
    in_rs1_data = 0; in_rs2_data = 0; in_use_pc = 0; in_use_imm = 0; in_alu_op = 0;
    in_rd_addr = 0; in_rd_we = 0; mem_rd_addr = 0; mem_rd_we = 0; mem_is_load = 0;
    mem_data = 0; wb_rd_addr = 0; wb_rd_we = 0; wb_data = 0; out_ready = 0;
  endtask

  task automatic send(input logic [4:0] r1, input logic [31:0] d1, input logic [4:0] r2,
                      input logic [31:0] d2, input logic [3:0] op);
    in_valid = 1; in_rs1_addr = r1; in_rs1_data = d1; in_rs2_addr = r2; in_rs2_data = d2;
    in_alu_op = op; in_pc = 32'h100; in_rd_addr = 5'd3; in_rd_we = 1;
  endtask

  task automatic drain();
    idle_in(); out_ready = 1; step(); out_ready = 0;
  endtask

  initial begin
    idle_in();
    model_reset();
    rst = 1;
    send(5'd5, 32'h10, 5'd6, 32'h22, 4'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_sel", sel_v, 0);
    chk("rst_ops", {operand_a, operand_b}, 0);
    chk("rst_ready", in_ready, 1);
    idle_in();
    rst = 0;
    step();

    send(5'd5, 32'h10, 5'd6, 32'h22, 4'd0);
    step();
    chk("add_valid", out_valid, 1);
    chk("add_a", operand_a, 32'h10);
    chk("add_b", operand_b, 32'h22);
    chk("add_sel", sel_v, 14'h1);
    drain();

    send(5'd7, 32'h1, 5'd0, 32'h0, 4'd7);
    mem_rd_we = 1; mem_rd_addr = 7; mem_data = 32'hAAAA;
    wb_rd_we = 1; wb_rd_addr = 7; wb_data = 32'hBBBB;
    step();
    chk("fwd_mem_a", operand_a, 32'hAAAA);
    out_ready = 1; in_rs1_addr = 0;
    step();
    chk("fwd_x0_a", operand_a, 32'h0);
    drain();

    send(5'd0, 32'h0, 5'd9, 32'h5555, 4'd1);
    mem_rd_we = 1; mem_rd_addr = 9; mem_is_load = 1;
    step();
    idle_in();
    out_ready = 1;
    #1;
    chk("ld_valid", out_valid, 0);
    chk("ld_ready", in_ready, 0);
    wb_rd_we = 1; wb_rd_addr = 9; wb_data = 32'h1234;
    out_ready = 0;
    step();
    chk("ld_done_valid", out_valid, 1);
    chk("ld_b", operand_b, 32'h1234);
    drain();

    send(5'd2, 32'h7, 5'd0, 32'h0, 4'd9);
    in_use_imm = 1; in_imm = 32'hFFFF_FFE3;
    step();
    idle_in();
    repeat (3) begin
      step();
      chk("bp_b", operand_b, 32'h3);
      chk("bp_sel", sel_v, 14'h200);
    end
    out_ready = 1;
    send(5'd5, 32'h10, 5'd6, 32'h22, 4'd0);
    #1;
    chk("b2b_ready", in_ready, 1);
    step();
    chk("b2b_valid", out_valid, 1);
    chk("b2b_sel", sel_v, 14'h1);
    drain();

    send(5'd1, 32'h9, 5'd2, 32'h8, 4'd6);
    step();
    send(5'd1, 32'h4, 5'd2, 32'h3, 4'd1);
    flush = 1; out_ready = 1;
    step();
    chk("flush_valid", out_valid, 0);
    idle_in();
    step();
    chk("flush_gone", out_valid, 0);
    chk("flush_sel", sel_v, 0);

    send(5'd1, 32'h9, 5'd2, 32'h8, 4'd8);
    step();
    rst = 1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_sel", sel_v, 0);
    idle_in();
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();

    for (int i = 0; i < 3000; i++) begin
      in_valid    = ($urandom_range(0, 9) < 7);
      out_ready   = ($urandom_range(0, 9) < 7);
      flush       = ($urandom_range(0, 31) == 0);
      in_pc       = $urandom; in_imm = $urandom;
      in_rs1_addr = 5'($urandom_range(0, 3)); in_rs2_addr = 5'($urandom_range(0, 3));
      in_rs1_data = $urandom; in_rs2_data = $urandom;
      in_use_pc   = $urandom_range(0, 1); in_use_imm = $urandom_range(0, 1);
      in_alu_op   = 4'($urandom_range(0, 15));
      in_rd_addr  = 5'($urandom_range(0, 31)); in_rd_we = $urandom_range(0, 1);
      mem_rd_we   = $urandom_range(0, 1); mem_rd_addr = 5'($urandom_range(0, 3));
      mem_is_load = ($urandom_range(0, 9) < 4); mem_data = $urandom;
      wb_rd_we    = $urandom_range(0, 1); wb_rd_addr = 5'($urandom_range(0, 3));
      wb_data     = $urandom;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
